// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN frame feeder.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    localparam int CNN_HEIGHT = 28;
    localparam int CNN_WIDTH  = 28;
    localparam int PIX_COUNT  = CNN_HEIGHT * CNN_WIDTH;

    // Clamp an accumulator word to an unsigned byte for the next layer.
    function automatic logic [7:0] sat8(input logic [63:0] word);
        return (|word[63:8]) ? 8'hFF : word[7:0];
    endfunction

endpackage

// File: rtl/cnn_result_drain.sv
// Snapshot of the accumulators and a valid/ready stream of the words.
// Optional 8-bit clamping of each word under CNN_FEEDER_SATURATE_EN.
module cnn_result_drain
    import cnn_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [DWIDTH*DEPTH-1:0]  acc_in,
    input  logic                     res_ready,
    output logic [DWIDTH-1:0]        res_data,
    output logic                     res_valid,
    output logic                     res_last,
    output logic                     done
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    logic [DEPTH-1:0][DWIDTH-1:0] snap;
    logic [IW-1:0]                idx;
    logic                         valid;
    logic                         xfer;
    logic                         at_last;
    logic [DWIDTH-1:0]            word;
    logic [DWIDTH-1:0]            out_word;

    // NOTE: the snapshot array is plain storage with no reset; valid gates every output.
    always_ff @(posedge clk) begin
        if (load) begin
            snap <= acc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            idx   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= '0;
        end else if (xfer) begin
            if (at_last) begin
                valid <= 1'b0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign xfer    = valid && res_ready;
    assign at_last = (idx == LAST_IDX);
    assign word    = snap[idx];

`ifdef CNN_FEEDER_SATURATE_EN
    assign out_word = DWIDTH'(sat8(64'(word)));
`else
    assign out_word = word;
`endif

    assign res_data  = valid ? out_word : '0;
    assign res_valid = valid;
    assign res_last  = valid && at_last;
    assign done      = xfer && at_last;

endmodule

// File: rtl/cnn_feeder.sv
// Frame sequencer for cnn_compute: clear, pixel address sweep, flush, drain.
// Define CNN_FEEDER_SATURATE_EN to clamp drained words to 8 bits.
module cnn_feeder
    import cnn_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int HEIGHT = CNN_HEIGHT,
    parameter int WIDTH  = CNN_WIDTH,
    parameter int DEPTH  = 8,
    localparam int AWIDTH = $clog2(HEIGHT * WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     sof,
    output logic                     en,
    output logic [AWIDTH-1:0]        rd_addr,
    input  logic [DWIDTH*DEPTH-1:0]  acc_in,
    output logic [DWIDTH-1:0]        res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_last
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(HEIGHT * WIDTH - 1);

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] pix_cnt;
    logic              flush_last;
    logic              load;
    logic              done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            flush_last <= 1'b0;
        end else begin
            state      <= state_next;
            pix_cnt    <= (state == RUN && pix_cnt != LAST_ADDR) ? pix_cnt + 1'b1 : '0;
            flush_last <= (state == FLUSH) && !flush_last;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can form.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        sof        = 1'b0;
        en         = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                sof        = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                en = 1'b1;
                if (pix_cnt == LAST_ADDR) state_next = FLUSH;
            end
            FLUSH: begin
                if (flush_last) begin
                    load       = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_addr = pix_cnt;

    cnn_result_drain #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_drain (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .acc_in    (acc_in),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_last  (res_last),
        .done      (done)
    );

endmodule

// File: tb/tb_cnn_feeder.sv
// Directed bench for cnn_feeder with HEIGHT=2, WIDTH=3, DEPTH=4 (N=6).
// Expected drained words follow CNN_FEEDER_SATURATE_EN when it is defined.
module tb_cnn_feeder;

    localparam int DW = 32;
    localparam int H  = 2;
    localparam int W  = 3;
    localparam int D  = 4;
    localparam int N  = H * W;
    localparam int AW = $clog2(N);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              sof;
    logic              en;
    logic [AW-1:0]     rd_addr;
    logic [DW*D-1:0]   acc_in;
    logic [DW-1:0]     res_data;
    logic              res_valid;
    logic              res_ready;
    logic              res_last;

    int n_checks = 0;
    int n_bad    = 0;

    cnn_feeder #(
        .DWIDTH (DW),
        .HEIGHT (H),
        .WIDTH  (W),
        .DEPTH  (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .sof       (sof),
        .en        (en),
        .rd_addr   (rd_addr),
        .acc_in    (acc_in),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_last  (res_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef CNN_FEEDER_SATURATE_EN
        return (w > 32'hFF) ? 32'hFF : w;
`else
        return w;
`endif
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  busy,      0);
        check({tag, "_sof"},   sof,       0);
        check({tag, "_en"},    en,        0);
        check({tag, "_addr"},  rd_addr,   0);
        check({tag, "_valid"}, res_valid, 0);
        check({tag, "_data"},  res_data,  0);
        check({tag, "_last"},  res_last,  0);
    endtask

    // Start on cycle 0 and check through the last FLUSH cycle (cycle N+3).
    task automatic run_front(input logic [DW*D-1:0] acc, input bit poke_in_run);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clr_sof", sof, 1);
        check("clr_en", en, 0);
        check("clr_busy", busy, 1);
        for (int k = 0; k < N; k++) begin
            tick();
            start = (poke_in_run && k == 2);
            check("run_en", en, 1);
            check("run_sof", sof, 0);
            check("run_addr", rd_addr, k);
        end
        start  = 1'b0;
        acc_in = acc;
        tick();
        check("fl1_en", en, 0);
        check("fl1_busy", busy, 1);
        check("fl1_valid", res_valid, 0);
        tick();
        check("fl2_en", en, 0);
        check("fl2_valid", res_valid, 0);
    endtask

    initial begin
        logic [31:0] vals [D];

        reset     = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;
        acc_in    = '0;
        repeat (3) tick();
        check_idle_outputs("rst");
        reset = 1'b0;
        tick();

        // Frame 1: timing plus drain order; acc_in changes during DRAIN.
        res_ready = 1'b1;
        run_front({32'd40, 32'd30, 32'd20, 32'd10}, 1'b0);
        for (int i = 0; i < D; i++) begin
            tick();
            acc_in = {4{32'hDEAD_BEEF}};
            check("f1_valid", res_valid, 1);
            check("f1_data", res_data, 10 * (i + 1));
            check("f1_last", res_last, (i == D - 1));
            check("f1_busy", busy, 1);
        end
        tick();
        check("f1_busy_fall", busy, 0);
        check("f1_valid_off", res_valid, 0);

        // Frame 2: three-cycle stall while word 1 is presented.
        tick();
        run_front({32'd40, 32'd30, 32'd20, 32'd10}, 1'b0);
        tick();
        check("f2_w0", res_data, 10);
        tick();
        res_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("f2_hold_data", res_data, 20);
            check("f2_hold_valid", res_valid, 1);
            check("f2_hold_last", res_last, 0);
            if (j < 2) tick();
        end
        res_ready = 1'b1;
        tick();
        check("f2_w2", res_data, 30);
        tick();
        check("f2_w3", res_data, 40);
        check("f2_w3_last", res_last, 1);
        tick();
        check("f2_done", busy, 0);

        // Frame 3: start poked during RUN and on the final DRAIN cycle.
        tick();
        run_front({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
        for (int i = 0; i < D; i++) begin
            tick();
            check("f3_data", res_data, i + 1);
            if (i == D - 1) start = 1'b1;
        end
        tick();
        start = 1'b0;
        check("f3_idle", busy, 0);
        tick();
        check("f3_no_restart_busy", busy, 0);
        check("f3_no_restart_sof", sof, 0);

        // Frame 4: reset on the third RUN cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("f4_run3_addr", rd_addr, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("midrst");
        tick();
        check_idle_outputs("postrst");

        // Frame 5: clean frame after reset, words around the 8-bit boundary.
        vals[0] = 32'h0000_0123;
        vals[1] = 32'h0000_007F;
        vals[2] = 32'h0000_00FF;
        vals[3] = 32'h0000_0100;
        run_front({vals[3], vals[2], vals[1], vals[0]}, 1'b0);
        for (int i = 0; i < D; i++) begin
            tick();
            check("f5_valid", res_valid, 1);
            check("f5_data", res_data, exp_word(vals[i]));
            check("f5_last", res_last, (i == D - 1));
        end
        tick();
        check("f5_done", busy, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
